// File: rtl/thresholding_pkg.sv
// Shared types and helpers for the pixel thresholding blocks.
// Covers the mode encoding, window size derivation and saturating arithmetic.
package thresholding_pkg;

  typedef enum logic {
    THR_FIXED    = 1'b0,
    THR_ADAPTIVE = 1'b1
  } thr_mode_e;

  function automatic int unsigned win_of(input int unsigned log_win);
    return 32'd1 << log_win;
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

  // Clamps a + b to maxv so callers can saturate at any pixel width.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] maxv);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, maxv}) ? maxv : s[31:0];
  endfunction

endpackage

// File: rtl/window_mean.sv
// Per-line sliding window of the last 2^LOG_WIN accepted pixels.
// Provides the window mean and a flag once the window has filled on this line.
module window_mean
  import thresholding_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int LOG_WIN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             clr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] mean,
  output logic             full
);

  localparam int WIN   = win_of(LOG_WIN);
  localparam int SUM_W = PIX_W + LOG_WIN;
  localparam logic [LOG_WIN:0] WIN_CNT = (LOG_WIN + 1)'(WIN);

  logic [PIX_W-1:0]   win_q [WIN];
  logic [SUM_W-1:0]   sum_q;
  logic [LOG_WIN:0]   fill_q;

  // Unfilled slots hold zero, so sum + new - oldest stays exact while filling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN; i++) win_q[i] <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else if (push) begin
      if (clr) begin
        for (int i = 0; i < WIN; i++) win_q[i] <= '0;
        sum_q  <= '0;
        fill_q <= '0;
      end else begin
        win_q[0] <= din;
        for (int i = 1; i < WIN; i++) win_q[i] <= win_q[i-1];
        sum_q <= sum_q + SUM_W'(din) - SUM_W'(win_q[WIN-1]);
        if (!full) fill_q <= fill_q + 1'b1;
      end
    end
  end

  assign full = (fill_q == WIN_CNT);
  assign mean = sum_q[SUM_W-1:LOG_WIN];

endmodule

// File: rtl/adaptive_threshold.sv
// Streaming pixel binariser: fixed or per-line running-mean threshold, two-stage pipeline.
// Optional hysteresis around the threshold is enabled with the THRESH_HYST_EN macro.
module adaptive_threshold
  import thresholding_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int LOG_WIN = 3,
  parameter int HYST    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             invert,
  input  logic             cfg_we,
  input  logic [PIX_W-1:0] thr_in,
  input  logic [PIX_W-1:0] off_in,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_last
);

`ifdef THRESH_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif
  localparam logic [31:0]      BAND     = HYST_ON ? 32'(HYST) : 32'd0;
  localparam logic [PIX_W-1:0] PIX_ONES = '1;
  localparam logic [PIX_W-1:0] THR_RST  = {1'b1, {(PIX_W-1){1'b0}}};

  logic             adv, accept;
  logic [PIX_W-1:0] thr_q, off_q;
  logic [PIX_W-1:0] win_mean;
  logic             win_full;
  logic [PIX_W-1:0] thr_cur;

  logic             s1_valid, s1_last, s1_invert;
  logic [PIX_W-1:0] s1_data, s1_thr;
  logic [PIX_W-1:0] thr_hi;
  logic             res_raw;

  assign adv     = m_ready | ~m_valid;
  assign s_ready = adv;
  assign accept  = s_valid & adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q <= THR_RST;
      off_q <= '0;
    end else if (cfg_we) begin
      thr_q <= thr_in;
      off_q <= off_in;
    end
  end

  window_mean #(.PIX_W(PIX_W), .LOG_WIN(LOG_WIN)) u_window (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .clr   (s_last),
    .din   (s_data),
    .mean  (win_mean),
    .full  (win_full)
  );

  // Window state is sampled before this pixel is shifted in, so it covers only earlier pixels.
  always_comb begin
    thr_cur = thr_q;
    if (thr_mode_e'(mode) == THR_ADAPTIVE && win_full)
      thr_cur = PIX_W'(sat_sub(32'(win_mean), 32'(off_q)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_thr    <= '0;
      s1_last   <= 1'b0;
      s1_invert <= 1'b0;
    end else if (adv) begin
      s1_valid <= s_valid;
      if (s_valid) begin
        s1_data   <= s_data;
        s1_thr    <= thr_cur;
        s1_last   <= s_last;
        s1_invert <= invert;
      end
    end
  end

  assign thr_hi = PIX_W'(sat_add(32'(s1_thr), BAND, 32'(PIX_ONES)));

`ifdef THRESH_HYST_EN
  logic [PIX_W-1:0] thr_lo;
  logic             hyst_q;

  assign thr_lo = PIX_W'(sat_sub(32'(s1_thr), BAND));

  always_comb begin
    res_raw = hyst_q;
    if (s1_data > thr_hi)      res_raw = 1'b1;
    else if (s1_data < thr_lo) res_raw = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                hyst_q <= 1'b0;
    else if (adv && s1_valid)  hyst_q <= s1_last ? 1'b0 : res_raw;
  end
`else
  always_comb begin
    res_raw = (s1_data > thr_hi);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (adv) begin
      m_valid <= s1_valid;
      if (s1_valid) begin
        m_data <= {PIX_W{res_raw ^ s1_invert}};
        m_last <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_adaptive_threshold.sv
// Self-checking bench for adaptive_threshold (LOG_WIN = 2); follows THRESH_HYST_EN if defined.
// Reference model recomputes each threshold from the list of pixels seen on the current line.
module tb_adaptive_threshold;

  localparam int PIX_W   = 8;
  localparam int LOG_WIN = 2;
  localparam int HYST    = 4;
  localparam int WIN     = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode, invert, cfg_we;
  logic [PIX_W-1:0] thr_in, off_in, s_data, m_data;
  logic             s_valid, s_ready, s_last;
  logic             m_valid, m_ready, m_last;

  adaptive_threshold #(.PIX_W(PIX_W), .LOG_WIN(LOG_WIN), .HYST(HYST)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .invert  (invert),
    .cfg_we  (cfg_we),
    .thr_in  (thr_in),
    .off_in  (off_in),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   hist[$];
  int   thr_m, off_m;
  bit   hyst_m;
  int   cyc, n_vec, n_err;
  bit   lat_check;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_pix(input int d, input bit md, input bit inv, input bit last,
                           output logic [7:0] res);
    int t, sum, hi, lo;
    bit r;
    if (md && hist.size() >= WIN) begin
      sum = 0;
      for (int i = hist.size() - WIN; i < hist.size(); i++) sum += hist[i];
      t = sum / WIN - off_m;
      if (t < 0) t = 0;
    end else begin
      t = thr_m;
    end
`ifdef THRESH_HYST_EN
    hi = (t + HYST > 255) ? 255 : t + HYST;
    lo = (t - HYST < 0) ? 0 : t - HYST;
    if (d > hi)      r = 1'b1;
    else if (d < lo) r = 1'b0;
    else             r = hyst_m;
    hyst_m = r;
`else
    hi = t; lo = t;
    r  = (d > t);
`endif
    res = (r ^ inv) ? 8'hFF : 8'h00;
    if (last) begin
      hist.delete();
      hyst_m = 1'b0;
    end else begin
      hist.push_back(d);
    end
  endtask

  // One clock: observe handshakes just after the drive point, update model, advance to next negedge.
  task automatic cycle();
    bit   acc, xf;
    exp_t e;
    logic [7:0] r;
    #1;
    acc = s_valid && s_ready;
    xf  = m_valid && m_ready;
    if (xf) begin
      chk("no_extra_output", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("m_data", m_data, e.d);
        chk("m_last", m_last, e.l);
        if (lat_check) chk("latency", cyc + 1 - e.acc, 2);
      end
    end
    if (acc) begin
      model_pix(s_data, mode, invert, s_last, r);
      e.d = r; e.l = s_last; e.acc = cyc + 1;
      q.push_back(e);
    end
    if (cfg_we) begin
      thr_m = thr_in;
      off_m = off_in;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic push_pix(input logic [7:0] d, input bit last);
    bit rdy, done;
    s_valid = 1'b1; s_data = d; s_last = last;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      rdy = s_ready;
      cycle();
      done = rdy;
    end
    if (!done) chk("push_timeout", 0, 1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain();
    s_valid = 1'b0; cfg_we = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 40 && q.size() > 0; k++) cycle();
    chk("drain_empty", q.size(), 0);
    repeat (3) cycle();
  endtask

  task automatic set_cfg(input logic [7:0] t, input logic [7:0] o);
    s_valid = 1'b0; cfg_we = 1'b1; thr_in = t; off_in = o;
    cycle();
    cfg_we = 1'b0;
  endtask

  initial begin
    logic [7:0] held;
    bit have, rdy;
    n_vec = 0; n_err = 0; cyc = 0; lat_check = 1'b0;
    rst_n = 1'b0; mode = 1'b0; invert = 1'b0; cfg_we = 1'b0;
    thr_in = '0; off_in = '0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    thr_m = 8'h80; off_m = 0; hyst_m = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_s_ready", s_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // fixed threshold, then inverted
    lat_check = 1'b1;
    set_cfg(8'h20, 8'h00);
    push_pix(8'h0F, 0); push_pix(8'h20, 0); push_pix(8'h21, 0); push_pix(8'h88, 1);
    drain();
    invert = 1'b1;
    push_pix(8'h0F, 0); push_pix(8'h20, 0); push_pix(8'h21, 0); push_pix(8'h88, 1);
    drain();
    invert = 1'b0;

    // adaptive with fixed fallback, then line clear
    set_cfg(8'h80, 8'h00);
    mode = 1'b1;
    push_pix(8'h10, 0); push_pix(8'h10, 0); push_pix(8'h10, 0); push_pix(8'h10, 0);
    push_pix(8'h11, 0); push_pix(8'h0F, 1);
    push_pix(8'h90, 1);
    drain();

    // adaptive with offset and saturation at zero
    set_cfg(8'h80, 8'h30);
    for (int i = 0; i < 4; i++) push_pix(8'h20, 0);
    push_pix(8'h01, 0); push_pix(8'h00, 0); push_pix(8'h60, 1);
    drain();
    mode = 1'b0;

    // hysteresis sequence around a fixed threshold
    set_cfg(8'h40, 8'h00);
    push_pix(8'h45, 0); push_pix(8'h3E, 0); push_pix(8'h3B, 0); push_pix(8'h43, 1);
    drain();

    // backpressure
    lat_check = 1'b0;
    have = 1'b0;
    s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (m_valid) begin
        if (!have) begin held = m_data; have = 1'b1; end
        chk("stall_s_ready", s_ready, 0);
        chk("stall_m_data", m_data, held);
      end
      rdy = s_ready;
      cycle();
      if (rdy) s_data = 8'($urandom);
    end
    chk("stall_seen", have, 1);
    m_ready = 1'b1;
    push_pix(s_data, 1);
    drain();

    // async reset with pixels in flight
    m_ready = 1'b0; mode = 1'b1;
    push_pix(8'h33, 0); push_pix(8'h44, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_data", m_data, 0);
    chk("midrst_m_last", m_last, 0);
    q.delete(); hist.delete(); hyst_m = 1'b0; thr_m = 8'h80; off_m = 0;
    m_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_s_ready", s_ready, 1);
    lat_check = 1'b1;
    push_pix(8'h90, 0); push_pix(8'h7F, 1);
    drain();

    // randomized traffic
    lat_check = 1'b0;
    for (int i = 0; i < 600; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'(8'h50 + $urandom_range(0, 8'h5F));
      s_last  = ($urandom_range(0, 6) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0)  mode   = ~mode;
      if ($urandom_range(0, 15) == 0) invert = ~invert;
      cfg_we = ($urandom_range(0, 19) == 0);
      if (cfg_we) begin
        thr_in = 8'($urandom_range(8'h40, 8'hC0));
        off_in = 8'($urandom_range(0, 8'h20));
      end
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
